bu2_fft_core: RTL and testbench

Radix-2 Cooley-Tukey (DIT) butterfly for the NWC/NTT datapath, operating modulo a run-time modulus.
- Accepts one operand pair plus a twiddle factor every clock; there is no input handshake.
- Produces fft_a = (in1 + in2·w) mod q and fft_b = (in1 − in2·w) mod q after a fixed pipeline latency.
- Forwards the twiddle and modulus, aligned with the results, so butterflies can be chained stage to stage.

---
 rtl/bu2_fft_core_pkg.sv | 6 +
 rtl/bu2_fft_core_if.sv | 24 ++
 rtl/bu2_fft_core_mod_mul.sv | 32 +++
 rtl/bu2_fft_core.sv | 85 ++++++++
 tb/tb_bu2_fft_core.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bu2_fft_core_pkg.sv
// Shared widths and pipeline constants for the radix-2 NTT butterfly.
package bu_pkg;
    localparam int unsigned D_WIDTH = 32;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned P_WIDTH = 2 * D_WIDTH;
endpackage

// File: rtl/bu2_fft_core_if.sv
// Butterfly data bus: operands, twiddle and modulus in; results and aligned twiddle/modulus out.
interface bu2_fft_core_if;
    import bu_pkg::*;

    logic [D_WIDTH-1:0] in1;
    logic [D_WIDTH-1:0] in2;
    logic [D_WIDTH-1:0] twiddle;
    logic [D_WIDTH-1:0] modulus;
    logic               BU_valid;
    logic [D_WIDTH-1:0] fft_a;
    logic [D_WIDTH-1:0] fft_b;
    logic [D_WIDTH-1:0] twiddle_BU_out;
    logic [D_WIDTH-1:0] modulus_BU_out;

    modport master (
        output in1, in2, twiddle, modulus,
        input  BU_valid, fft_a, fft_b, twiddle_BU_out, modulus_BU_out
    );

    modport slave (
        input  in1, in2, twiddle, modulus,
        output BU_valid, fft_a, fft_b, twiddle_BU_out, modulus_BU_out
    );
endinterface

// File: rtl/bu2_fft_core_mod_mul.sv
// Registered modular multiply: r = (a * b) mod q, one cycle latency.
module mod_mul
    import bu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    input  logic [D_WIDTH-1:0] q,
    output logic [D_WIDTH-1:0] r
);
    logic [P_WIDTH-1:0] prod;
    logic [D_WIDTH-1:0] r_d;

    always_comb begin
        prod = {{D_WIDTH{1'b0}}, a} * {{D_WIDTH{1'b0}}, b};
        // q is 0 only while the pipeline is still holding reset values
        if (q == '0) begin
            r_d = '0;
        end else begin
            r_d = D_WIDTH'(prod % {{D_WIDTH{1'b0}}, q});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else begin
            r <= r_d;
        end
    end
endmodule

// File: rtl/bu2_fft_core.sv
// Radix-2 DIT butterfly mod q: a = in1 + in2*w, b = in1 - in2*w, three-cycle pipeline.
module bu2_fft_core
    import bu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    bu2_fft_core_if.slave     bus
);
    logic [D_WIDTH-1:0] in1_s1_q, in2_s1_q, tw_s1_q, q_s1_q;
    logic [D_WIDTH-1:0] in1_s2_q, tw_s2_q, q_s2_q;
    logic [D_WIDTH-1:0] t_s2;
    logic [D_WIDTH-1:0] a_s3_q, b_s3_q, tw_s3_q, q_s3_q;
    logic [D_WIDTH-1:0] a_d, b_d;
    logic [D_WIDTH:0]   sum;
    logic [1:0]         cnt_q, cnt_d;
    logic               valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_s1_q <= '0;
            in2_s1_q <= '0;
            tw_s1_q  <= '0;
            q_s1_q   <= '0;
            in1_s2_q <= '0;
            tw_s2_q  <= '0;
            q_s2_q   <= '0;
            a_s3_q   <= '0;
            b_s3_q   <= '0;
            tw_s3_q  <= '0;
            q_s3_q   <= '0;
            cnt_q    <= '0;
        end else begin
            in1_s1_q <= bus.in1;
            in2_s1_q <= bus.in2;
            tw_s1_q  <= bus.twiddle;
            q_s1_q   <= bus.modulus;
            in1_s2_q <= in1_s1_q;
            tw_s2_q  <= tw_s1_q;
            q_s2_q   <= q_s1_q;
            a_s3_q   <= a_d;
            b_s3_q   <= b_d;
            tw_s3_q  <= tw_s2_q;
            q_s3_q   <= q_s2_q;
            cnt_q    <= cnt_d;
        end
    end

    mod_mul u_mod_mul (
        .clk (clk),
        .rst (rst),
        .a   (in2_s1_q),
        .b   (tw_s1_q),
        .q   (q_s1_q),
        .r   (t_s2)
    );

    always_comb begin
        sum = {1'b0, in1_s2_q} + {1'b0, t_s2};
        if (sum >= {1'b0, q_s2_q}) begin
            a_d = D_WIDTH'(sum - {1'b0, q_s2_q});
        end else begin
            a_d = D_WIDTH'(sum);
        end
        // Wrap-around subtraction, then add q back when it went negative
        b_d = in1_s2_q - t_s2;
        if (in1_s2_q < t_s2) begin
            b_d = b_d + q_s2_q;
        end
    end

    // Warm-up counter saturates once the pipeline is full
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
        end
        valid = (cnt_q == 2'd3);
    end

    assign bus.BU_valid       = valid;
    assign bus.fft_a          = valid ? a_s3_q : '0;
    assign bus.fft_b          = valid ? b_s3_q : '0;
    assign bus.twiddle_BU_out = tw_s3_q;
    assign bus.modulus_BU_out = q_s3_q;
endmodule

// File: tb/tb_bu2_fft_core.sv
// Self-checking bench for bu2_fft_core: behavioural mod-q model plus literal vectors.
module tb_bu2_fft_core;
    import bu_pkg::*;

    localparam int unsigned Q = 7681;
    localparam int unsigned NMAX = 1024;

    logic clk;
    logic rst;
    bu2_fft_core_if bus();

    bu2_fft_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sample log indexed by edge number since reset release
    int unsigned edges;
    longint unsigned s_in1 [NMAX];
    longint unsigned s_in2 [NMAX];
    longint unsigned s_tw  [NMAX];
    longint unsigned s_q   [NMAX];

    bit              lit_valid [NMAX];
    longint unsigned lit_a     [NMAX];
    longint unsigned lit_b     [NMAX];

    bit          rand_active = 0;
    int unsigned rand_lo = 0;
    int unsigned rand_hi = 0;
    int          rand_seen = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edges <= 0;
        end else begin
            edges <= edges + 1;
            if (edges + 1 < NMAX) begin
                s_in1[edges+1] <= longint'(bus.in1);
                s_in2[edges+1] <= longint'(bus.in2);
                s_tw[edges+1]  <= longint'(bus.twiddle);
                s_q[edges+1]   <= longint'(bus.modulus);
            end
        end
    end

    // Compare process: every falling edge, check against the arithmetic model
    always @(negedge clk) begin
        longint unsigned t, ea, eb;
        int unsigned n;
        if (!rst) begin
            chk("reset_valid", 64'(bus.BU_valid), 0);
            chk("reset_a", 64'(bus.fft_a), 0);
            chk("reset_b", 64'(bus.fft_b), 0);
            chk("reset_tw", 64'(bus.twiddle_BU_out), 0);
            chk("reset_mod", 64'(bus.modulus_BU_out), 0);
        end else if (edges < 3) begin
            chk("warmup_valid", 64'(bus.BU_valid), 0);
            chk("warmup_a", 64'(bus.fft_a), 0);
            chk("warmup_b", 64'(bus.fft_b), 0);
        end else begin
            n = edges - 2;
            t  = (s_in2[n] * s_tw[n]) % s_q[n];
            ea = (s_in1[n] + t) % s_q[n];
            eb = (s_in1[n] + s_q[n] - t) % s_q[n];
            chk("valid", 64'(bus.BU_valid), 1);
            chk("model_a", 64'(bus.fft_a), ea);
            chk("model_b", 64'(bus.fft_b), eb);
            chk("model_tw", 64'(bus.twiddle_BU_out), s_tw[n]);
            chk("model_mod", 64'(bus.modulus_BU_out), s_q[n]);
            if (lit_valid[n]) begin
                chk("literal_a", 64'(bus.fft_a), lit_a[n]);
                chk("literal_b", 64'(bus.fft_b), lit_b[n]);
            end
            if (rand_active && n >= rand_lo && n <= rand_hi && bus.BU_valid) begin
                rand_seen++;
            end
        end
    end

    // Drive one sample at a falling edge; it is taken on the next rising edge
    task automatic drive(input int unsigned i1, input int unsigned i2, input int unsigned w,
                         input int unsigned q, input bit lit, input int unsigned ea,
                         input int unsigned eb);
        int unsigned idx;
        @(negedge clk);
        idx = edges + 1;
        bus.in1     = i1;
        bus.in2     = i2;
        bus.twiddle = w;
        bus.modulus = q;
        lit_valid[idx] = lit;
        lit_a[idx]     = ea;
        lit_b[idx]     = eb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        bus.in1 = 0;
        bus.in2 = 0;
        bus.twiddle = 0;
        bus.modulus = 0;
        for (int i = 0; i < NMAX; i++) lit_valid[i] = 0;
        repeat (3) @(negedge clk);

        drive(1, 2, 3, Q, 1, 7, 7676);
        #1 rst = 1;
        // Pin the model's twiddle/modulus alignment on the first vector
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("first_tw", 64'(bus.twiddle_BU_out), 3);
        chk("first_mod", 64'(bus.modulus_BU_out), 7681);
        drive(7680, 7680, 7680, Q, 1, 0, 7679);
        drive(5, 5, 1, Q, 1, 10, 0);
        drive(9, 100, 0, Q, 1, 9, 9);
        drive(7680, 1, 1, Q, 1, 0, 7679);
        drive(3, 1, 3, Q, 1, 6, 0);

        rand_lo = edges + 2;
        rand_hi = rand_lo + 95;
        rand_active = 1;
        for (int i = 0; i < 96; i++) begin
            drive($urandom_range(Q - 1), $urandom_range(Q - 1), $urandom_range(Q - 1), Q,
                  0, 0, 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, Q, 0, 0, 0);
        chk("random_count", 64'(rand_seen), 96);
        rand_active = 0;

        // Reset mid-stream while samples are in flight
        drive(11, 22, 33, Q, 0, 0, 0);
        drive(44, 55, 66, Q, 0, 0, 0);
        #2 rst = 0;
        #1;
        chk("async_valid_drop", 64'(bus.BU_valid), 0);
        chk("async_a_zero", 64'(bus.fft_a), 0);
        chk("async_b_zero", 64'(bus.fft_b), 0);
        chk("async_mod_zero", 64'(bus.modulus_BU_out), 0);
        for (int i = 0; i < NMAX; i++) lit_valid[i] = 0;
        @(negedge clk);
        drive(100, 3, 4, Q, 1, 112, 88);
        #1 rst = 1;
        drive(200, 7000, 2, Q, 0, 0, 0);
        drive(7679, 7680, 7680, Q, 1, 7680, 7678);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, Q, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
